// File: rtl/sim_mailbox_pkg.sv
// Shared definitions for the test-completion mailbox: register offsets,
// STATUS bit positions and the byte-strobe merge helper.
package sim_mailbox_pkg;

    localparam logic [3:0] OFF_RESULT = 4'h0;
    localparam logic [3:0] OFF_DONE   = 4'h4;
    localparam logic [3:0] OFF_CYCLES = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_PASS_BIT    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;

    // Word offset inside the window; the byte-within-word bits are ignored.
    function automatic logic [3:0] word_offset(input logic [3:0] addr_low);
        return {addr_low[3:2], 2'b00};
    endfunction

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sim_mailbox_regs.sv
// Mailbox register file: RESULT and DONE_REG storage with byte-lane writes,
// plus the read mux over all four words of the window.
module sim_mailbox_regs
    import sim_mailbox_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  offset,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [31:0] cycles,
    input  logic [31:0] status,
    output logic [31:0] result,
    output logic [31:0] done_reg,
    output logic [31:0] result_next,
    output logic [31:0] rdata
);

    logic [31:0] result_q, result_d;
    logic [31:0] done_reg_q, done_reg_d;

    // Apply an accepted store to the addressed writable register; CYCLES and STATUS ignore stores.
    always_comb begin
        result_d   = result_q;
        done_reg_d = done_reg_q;
        if (wr_en) begin
            case (offset)
                OFF_RESULT: result_d   = merge(result_q, wdata, wstrb);
                OFF_DONE:   done_reg_d = merge(done_reg_q, wdata, wstrb);
                default:    ;
            endcase
        end
    end

    // Register storage, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            done_reg_q <= '0;
        end else begin
            result_q   <= result_d;
            done_reg_q <= done_reg_d;
        end
    end

    // Read mux returns the pre-write register contents.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_RESULT: rdata = result_q;
            OFF_DONE:   rdata = done_reg_q;
            OFF_CYCLES: rdata = cycles;
            OFF_STATUS: rdata = status;
            default:    rdata = '0;
        endcase
    end

    assign result      = result_q;
    assign done_reg    = done_reg_q;
    assign result_next = result_d;

endmodule

// File: rtl/sim_mailbox.sv
// Test-completion mailbox: bus handshake, done/pass/timeout tracking and
// the free-running cycle counter that freezes at completion or timeout.
module sim_mailbox
    import sim_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
    parameter logic [31:0] DONE_MAGIC     = 32'hDEAD_BEEF,
    parameter logic [31:0] EXPECTED       = 32'd2,
    parameter int unsigned TIMEOUT_CYCLES = 10000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        hit,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] result,
    output logic [31:0] cycles
);

    localparam logic        TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST    = 32'(TIMEOUT_CYCLES) - 32'd1;

    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cycles_q, cycles_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        wr_en;
    logic        rd_en;
    logic        done_fire;
    logic [3:0]  offset;
    logic [31:0] status;
    logic [31:0] done_reg;
    logic [31:0] result_next;
    logic [31:0] reg_rdata;

    // Address decode and handshake; a second load is held off while a response is on the bus.
    always_comb begin
        hit       = (req_addr[31:4] == BASE_ADDR[31:4]);
        offset    = word_offset(req_addr[3:0]);
        req_ready = !(rsp_valid_q && req_valid && !req_we);
        wr_en     = req_valid && req_ready && hit && req_we;
        rd_en     = req_valid && req_ready && hit && !req_we;
    end

    // Completion fires one cycle after DONE_REG holds the magic value; pass sees any same-cycle RESULT write.
    always_comb begin
        done_fire = !done_q && (done_reg == DONE_MAGIC);
        done_d    = done_q;
        pass_d    = pass_q;
        if (done_fire) begin
            done_d = 1'b1;
            pass_d = !timeout_q && (result_next == EXPECTED);
        end
    end

    // Saturating cycle counter and sticky timeout, with completion taking priority on a tie.
    always_comb begin
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        if (!done_q && !timeout_q && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end
        if (TIMEOUT_ENABLED && !timeout_q && !done_q && !done_fire && (cycles_d == TIMEOUT_LAST)) begin
            timeout_d = 1'b1;
        end
    end

    // Load response register; read data holds between responses.
    always_comb begin
        rsp_valid_d = rd_en;
        rsp_rdata_d = rd_en ? reg_rdata : rsp_rdata_q;
    end

    // Control state, cleared by reset so any in-flight response is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // STATUS word presented to the read mux.
    always_comb begin
        status                     = '0;
        status[STATUS_DONE_BIT]    = done_q;
        status[STATUS_PASS_BIT]    = pass_q;
        status[STATUS_TIMEOUT_BIT] = timeout_q;
    end

    sim_mailbox_regs u_regs (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .offset      (offset),
        .wdata       (req_wdata),
        .wstrb       (req_wstrb),
        .cycles      (cycles_q),
        .status      (status),
        .result      (result),
        .done_reg    (done_reg),
        .result_next (result_next),
        .rdata       (reg_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_sim_mailbox.sv
// Bench for sim_mailbox: a hand-computed vector table, directed corner
// sequences and randomized traffic compared against a byte-level model.
module tb_sim_mailbox;

    localparam logic [31:0] BASE     = 32'h8000_1000;
    localparam logic [31:0] MAGIC    = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_RES  = 32'd2;
    localparam int          TMO      = 20;
    localparam logic [31:0] TMO_LAST = 32'd19;

    localparam logic [31:0] A_RES = BASE;
    localparam logic [31:0] A_DON = BASE + 32'd4;
    localparam logic [31:0] A_CYC = BASE + 32'd8;
    localparam logic [31:0] A_STA = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        hit;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] result;
    logic [31:0] cycles;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: registers kept as byte lanes.
    logic [7:0]  m_res [4];
    logic [7:0]  m_dreg[4];
    logic        m_done, m_pass, m_tmo, m_rv;
    logic [31:0] m_cyc, m_rd;

    typedef struct {
        logic        r, v, we;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        logic        e_done, e_pass, e_rv;
        logic [31:0] e_rd, e_res, e_cyc;
    } vec_t;

    vec_t tbl[28];

    sim_mailbox #(
        .BASE_ADDR      (BASE),
        .DONE_MAGIC     (MAGIC),
        .EXPECTED       (EXP_RES),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .hit       (hit),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .result    (result),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, v, we, input logic [31:0] a, wd, input logic [3:0] ws,
                                input logic e_done, e_pass, e_rv, input logic [31:0] e_rd, e_res, e_cyc);
        vec_t t;
        t.r = r; t.v = v; t.we = we; t.a = a; t.wd = wd; t.ws = ws;
        t.e_done = e_done; t.e_pass = e_pass; t.e_rv = e_rv;
        t.e_rd = e_rd; t.e_res = e_res; t.e_cyc = e_cyc;
        return t;
    endfunction

    function automatic logic [31:0] mResult();
        return {m_res[3], m_res[2], m_res[1], m_res[0]};
    endfunction

    function automatic logic [31:0] mDoneReg();
        return {m_dreg[3], m_dreg[2], m_dreg[1], m_dreg[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_res[i]  = 8'h00;
            m_dreg[i] = 8'h00;
        end
        m_done = 1'b0; m_pass = 1'b0; m_tmo = 1'b0; m_rv = 1'b0;
        m_cyc  = '0;   m_rd   = '0;
    endtask

    // One clock of the mailbox rules applied to the model.
    task automatic modelStep(input logic r, v, we, input logic [31:0] a, wd, input logic [3:0] ws);
        logic        accept;
        logic        fire;
        logic [31:0] rd_now;
        logic [31:0] new_cyc;
        int          idx;
        if (r) begin
            modelReset();
            return;
        end
        accept = v && (a[31:4] == BASE[31:4]) && !(m_rv && !we);
        idx    = int'(a[3:2]);
        case (idx)
            0:       rd_now = mResult();
            1:       rd_now = mDoneReg();
            2:       rd_now = m_cyc;
            default: rd_now = {29'b0, m_tmo, m_pass, m_done};
        endcase
        fire = !m_done && (mDoneReg() == MAGIC);
        if (accept && we && idx < 2) begin
            for (int i = 0; i < 4; i++) begin
                if (ws[i]) begin
                    if (idx == 0) m_res[i]  = wd[8*i +: 8];
                    else          m_dreg[i] = wd[8*i +: 8];
                end
            end
        end
        new_cyc = (!m_done && !m_tmo && m_cyc != 32'hFFFF_FFFF) ? m_cyc + 32'd1 : m_cyc;
        if (fire) begin
            m_pass = !m_tmo && (mResult() == EXP_RES);
            m_done = 1'b1;
        end else if (!m_done && !m_tmo && new_cyc == TMO_LAST) begin
            m_tmo = 1'b1;
        end
        m_cyc = new_cyc;
        if (accept && !we) begin
            m_rv = 1'b1;
            m_rd = rd_now;
        end else begin
            m_rv = 1'b0;
        end
    endtask

    task automatic compareModel();
        checkFlag("done", done, m_done);
        checkFlag("pass", pass, m_pass);
        checkFlag("timeout", timeout, m_tmo);
        checkOutput("result", result, mResult());
        checkOutput("cycles", cycles, m_cyc);
        checkFlag("rsp_valid", rsp_valid, m_rv);
        checkOutput("rsp_rdata", rsp_rdata, m_rd);
    endtask

    // Drive one cycle of bus inputs, check combinational outputs, clock, then check registered state.
    task automatic applyStimulus(input logic r, v, we, input logic [31:0] a, wd, input logic [3:0] ws);
        rst = r; req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
        #1;
        checkFlag("hit", hit, a[31:4] == BASE[31:4]);
        if (!r) checkFlag("req_ready", req_ready, !(m_rv && v && !we));
        modelStep(r, v, we, a, wd, ws);
        @(posedge clk);
        #1;
        compareModel();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, A_RES, 32'h0, 4'h0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, A_RES, 32'h0, 4'h0);
    endtask

    initial begin
        modelReset();

        tbl[0]  = mk(1, 0, 0, A_RES, 32'h0,          4'h0, 0, 0, 0, 32'h0, 32'h0, 32'd0);
        tbl[1]  = mk(0, 1, 1, A_RES, 32'h2,          4'hF, 0, 0, 0, 32'h0, 32'h2, 32'd1);
        tbl[2]  = mk(0, 1, 1, A_DON, MAGIC,          4'hF, 0, 0, 0, 32'h0, 32'h2, 32'd2);
        tbl[3]  = mk(0, 0, 0, A_RES, 32'h0,          4'h0, 1, 1, 0, 32'h0, 32'h2, 32'd3);
        tbl[4]  = mk(0, 1, 0, A_STA, 32'h0,          4'h0, 1, 1, 1, 32'h3, 32'h2, 32'd3);
        tbl[5]  = mk(0, 0, 0, A_RES, 32'h0,          4'h0, 1, 1, 0, 32'h3, 32'h2, 32'd3);
        tbl[6]  = mk(0, 1, 0, A_CYC, 32'h0,          4'h0, 1, 1, 1, 32'h3, 32'h2, 32'd3);
        tbl[7]  = mk(1, 0, 0, A_RES, 32'h0,          4'h0, 0, 0, 0, 32'h0, 32'h0, 32'd0);
        tbl[8]  = mk(0, 1, 1, A_RES, 32'h5,          4'hF, 0, 0, 0, 32'h0, 32'h5, 32'd1);
        tbl[9]  = mk(0, 1, 1, A_DON, MAGIC,          4'hF, 0, 0, 0, 32'h0, 32'h5, 32'd2);
        tbl[10] = mk(0, 0, 0, A_RES, 32'h0,          4'h0, 1, 0, 0, 32'h0, 32'h5, 32'd3);
        tbl[11] = mk(0, 1, 0, A_STA, 32'h0,          4'h0, 1, 0, 1, 32'h1, 32'h5, 32'd3);
        tbl[12] = mk(1, 0, 0, A_RES, 32'h0,          4'h0, 0, 0, 0, 32'h0, 32'h0, 32'd0);
        tbl[13] = mk(0, 1, 1, A_RES, 32'h2,          4'hF, 0, 0, 0, 32'h0, 32'h2, 32'd1);
        tbl[14] = mk(0, 1, 1, A_DON, 32'h0000_00EF,  4'h1, 0, 0, 0, 32'h0, 32'h2, 32'd2);
        tbl[15] = mk(0, 1, 1, A_DON, 32'h0000_BE00,  4'h2, 0, 0, 0, 32'h0, 32'h2, 32'd3);
        tbl[16] = mk(0, 1, 1, A_DON, 32'h00AD_0000,  4'h4, 0, 0, 0, 32'h0, 32'h2, 32'd4);
        tbl[17] = mk(0, 1, 1, A_DON, 32'hDE00_0000,  4'h8, 0, 0, 0, 32'h0, 32'h2, 32'd5);
        tbl[18] = mk(0, 0, 0, A_RES, 32'h0,          4'h0, 1, 1, 0, 32'h0, 32'h2, 32'd6);
        tbl[19] = mk(1, 0, 0, A_RES, 32'h0,          4'h0, 0, 0, 0, 32'h0, 32'h0, 32'd0);
        tbl[20] = mk(0, 1, 1, A_RES, 32'h7,          4'hF, 0, 0, 0, 32'h0, 32'h7, 32'd1);
        tbl[21] = mk(0, 1, 1, A_DON, 32'h0000_BEEF,  4'h3, 0, 0, 0, 32'h0, 32'h7, 32'd2);
        tbl[22] = mk(0, 1, 1, A_DON, 32'hDEAD_0000,  4'hC, 0, 0, 0, 32'h0, 32'h7, 32'd3);
        tbl[23] = mk(0, 1, 1, A_RES, 32'hFFFF_0002,  4'h3, 1, 1, 0, 32'h0, 32'h2, 32'd4);
        tbl[24] = mk(1, 0, 0, A_RES, 32'h0,          4'h0, 0, 0, 0, 32'h0, 32'h0, 32'd0);
        tbl[25] = mk(0, 1, 1, 32'h7FFF_FFFC, MAGIC,  4'hF, 0, 0, 0, 32'h0, 32'h0, 32'd1);
        tbl[26] = mk(0, 1, 1, A_RES, 32'h55,         4'h0, 0, 0, 0, 32'h0, 32'h0, 32'd2);
        tbl[27] = mk(0, 1, 0, BASE + 32'hE, 32'h0,   4'h0, 0, 0, 1, 32'h0, 32'h0, 32'd3);

        for (int i = 0; i < 28; i++) begin
            applyStimulus(tbl[i].r, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].ws);
            checkFlag($sformatf("vec%0d_done", i), done, tbl[i].e_done);
            checkFlag($sformatf("vec%0d_pass", i), pass, tbl[i].e_pass);
            checkFlag($sformatf("vec%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
            checkOutput($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, tbl[i].e_rd);
            checkOutput($sformatf("vec%0d_result", i), result, tbl[i].e_res);
            checkOutput($sformatf("vec%0d_cycles", i), cycles, tbl[i].e_cyc);
            checkFlag($sformatf("vec%0d_timeout", i), timeout, 1'b0);
        end

        // Back-to-back loads: the second one is held off for a cycle.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, A_CYC, 32'h0, 4'h0);
        checkFlag("b2b_first_valid", rsp_valid, 1'b1);
        checkOutput("b2b_first_data", rsp_rdata, 32'd0);
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = A_CYC;
        #1;
        checkFlag("b2b_ready_low", req_ready, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, A_CYC, 32'h0, 4'h0);
        checkFlag("b2b_stalled", rsp_valid, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, A_CYC, 32'h0, 4'h0);
        checkFlag("b2b_second_valid", rsp_valid, 1'b1);
        checkOutput("b2b_second_data", rsp_rdata, 32'd2);

        // Reset while a response is on the bus drops it.
        applyStimulus(1'b1, 1'b1, 1'b0, A_CYC, 32'h0, 4'h0);
        checkFlag("rst_drop_valid", rsp_valid, 1'b0);
        checkOutput("rst_drop_data", rsp_rdata, 32'h0);
        idle(1);
        checkFlag("rst_no_late_rsp", rsp_valid, 1'b0);

        // Timeout with no stores, then a late magic store.
        doReset();
        idle(25);
        checkFlag("tmo_flag", timeout, 1'b1);
        checkOutput("tmo_cycles", cycles, 32'd19);
        applyStimulus(1'b0, 1'b1, 1'b1, A_RES, 32'h2, 4'hF);
        applyStimulus(1'b0, 1'b1, 1'b1, A_DON, MAGIC, 4'hF);
        idle(1);
        checkFlag("tmo_late_done", done, 1'b1);
        checkFlag("tmo_late_pass", pass, 1'b0);

        // Completion and timeout on the same edge: completion wins.
        doReset();
        idle(17);
        applyStimulus(1'b0, 1'b1, 1'b1, A_DON, MAGIC, 4'hF);
        idle(1);
        checkFlag("tie_done", done, 1'b1);
        checkFlag("tie_timeout", timeout, 1'b0);
        checkOutput("tie_cycles", cycles, 32'd19);
        idle(3);
        checkFlag("tie_timeout_later", timeout, 1'b0);
        checkOutput("tie_cycles_frozen", cycles, 32'd19);

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            logic        r, v, we;
            logic [31:0] a, wd;
            logic [3:0]  ws;
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) != 0);
            a  = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       wd = MAGIC;
                1:       wd = EXP_RES;
                2:       wd = $urandom;
                default: wd = MAGIC ^ (32'h1 << $urandom_range(0, 31));
            endcase
            ws = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            applyStimulus(r, v, we, a, wd, ws);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sim_mailbox.md
Name: sim_mailbox

Overview:
- Memory-mapped test-completion mailbox on the core's data-memory bus, alongside the main byte memory.
- Claims the word window 0x8000_1000..0x8000_100F. Latches the program's result word and detects the 0xDEADBEEF done signature, including when it is written as partial-byte stores.
- Counts cycles and times out.
- Raises done/pass/timeout flags for the bench and FPGA top, so completion no longer depends on polling raw memory bytes.

Parameters:
- BASE_ADDR, 32'h8000_1000: word-aligned base of the 16-byte window.
- DONE_MAGIC, 32'hDEAD_BEEF: signature that marks completion.
- EXPECTED, 32'd2: result value that counts as pass.
- TIMEOUT_CYCLES, 10000: cycles after reset release before timeout is asserted. 0 disables timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  bus request valid
- req_ready  out  1  mailbox accepts request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, little-endian lanes
- req_wstrb  in  4  byte-lane enables, bit i = byte lane i
- rsp_valid  out  1  load data valid
- rsp_rdata  out  32  load data
- hit  out  1  combinational: req_addr[31:4] == BASE_ADDR[31:4]; the memory must ignore the request when hit=1
- done  out  1  sticky completion flag
- pass  out  1  done && result == EXPECTED, sampled at the done event
- timeout  out  1  sticky timeout flag
- result  out  32  current RESULT register
- cycles  out  32  cycle counter

Behaviour:
- Reset (rst=1 on a clk edge):
  - RESULT=0, DONE_REG=0, cycles=0.
  - done=0, pass=0, timeout=0, rsp_valid=0, rsp_rdata=0.
  - req_ready=1 combinationally after reset.
  - Reset mid-operation drops any pending response. No response appears in the cycle after reset.
- Handshake:
  - A transfer occurs when req_valid && req_ready && hit. Non-hit requests are ignored entirely.
  - req_ready=0 only in the cycle a load response is pending and a new load would collide; stores are always accepted.
- Register map (offset from BASE_ADDR; addr[1:0] ignored, wstrb selects lanes):
  - 0x0 RESULT: R/W.
  - 0x4 DONE_REG: R/W.
  - 0x8 CYCLES: RO; stores are ignored.
  - 0xC STATUS: RO; {29'b0, timeout, pass, done}.
- Stores:
  - Per-lane update: lane i is written iff wstrb[i].
  - wstrb=0 is a legal no-op.
- Done detection:
  - Evaluated on the post-write value of DONE_REG, so a magic value assembled from four byte stores or two halfword stores triggers.
  - Fires in the cycle after the completing store: done goes 1 at the following edge.
  - pass is latched at the same edge, using RESULT including any same-cycle write.
  - After done=1:
    - done and pass are frozen.
    - Further writes still update the registers but do not change done or pass.
    - cycles stops counting.
- Loads:
  - Fixed 1-cycle latency: rsp_valid=1 exactly one cycle after acceptance, with rsp_rdata equal to the register value before any write in that acceptance cycle.
  - rsp_rdata holds its value when rsp_valid=0.
- Cycle counter:
  - Increments every cycle while !rst && !done && !timeout.
  - Saturates at 32'hFFFF_FFFF; no wrap.
- Timeout:
  - Asserted when cycles reaches TIMEOUT_CYCLES-1 and done=0; sticky.
  - If done and timeout would assert in the same cycle, done wins and timeout stays 0.
  - A store completing DONE_MAGIC after timeout still sets done, but pass is forced to 0.
- Overwriting DONE_REG with a non-magic value before completion is harmless.

Decomposition:
- Shared package sim_mailbox_pkg:
  - Offsets OFF_RESULT, OFF_DONE, OFF_CYCLES, OFF_STATUS.
  - STATUS bit indices.
  - The strobe-merge function: merge(old, wdata, wstrb) returns a 32-bit value.
- One natural sub-module: sim_mailbox_regs, holding the register file, strobe merge and read mux.
- The top-level block holds the handshake, done/pass/timeout control and the counter.

Test Plan:
- Full-word store RESULT=2, then DONE_REG=0xDEADBEEF with wstrb=4'hF -> done=1 and pass=1 one cycle later; result=2; cycles frozen.
- Byte stores EF, BE, AD, DE to lanes 0..3 in separate cycles with RESULT=2 -> done rises only after the 4th store; pass=1.
- RESULT=5, then magic -> done=1, pass=0; STATUS load returns 32'h1 with rsp_valid exactly one cycle after request.
- TIMEOUT_CYCLES=20, no stores -> timeout=1 at cycle 19, cycles holds 19; a later magic store gives done=1, pass=0.
- Load CYCLES, then assert rst mid-response -> rsp_valid=0; all outputs at reset values; store to 0x7FFF_FFFC leaves hit=0 and state unchanged.
- Same-cycle RESULT write with final magic byte, where the RESULT write lands through a halfword store with wstrb=4'b0011 -> pass uses the new RESULT.
